// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: bus widths, capacity
// default and the FSM state encoding.
package instr_mem_loader_pkg;

    localparam int INSTRUCTION_LEN      = 32;
    localparam int INSTRUCTION_MEM_LEN  = 8;
    localparam int INSTRUCTION_MEM_SIZE = 256;
    localparam int MAX_WORDS_DEFAULT    = INSTRUCTION_MEM_SIZE / 4;
    localparam int LANES                = INSTRUCTION_LEN / INSTRUCTION_MEM_LEN;

    typedef enum logic [1:0] {
        LDR_IDLE  = 2'd0,
        LDR_RECV  = 2'd1,
        LDR_WRITE = 2'd2,
        LDR_DONE  = 2'd3
    } ldr_state_e;

endpackage

// File: rtl/instr_mem_loader_word_assembler.sv
// Packs incoming bytes big-endian into one instruction word; lane 0 lands in
// the most significant byte. Flags when the word is complete.
module loader_word_assembler
    import instr_mem_loader_pkg::*;
(
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clear,
    input  logic                           accept,
    input  logic [INSTRUCTION_MEM_LEN-1:0] byte_data,
    input  logic                           byte_last,
    output logic [INSTRUCTION_LEN-1:0]     word,
    output logic                           complete,
    output logic                           partial
);

    localparam int PW = $clog2(LANES);

    logic [LANES-1:0][INSTRUCTION_MEM_LEN-1:0] lanes, lanes_n;
    logic [PW-1:0]                             pos;

    // A final byte short of a full word zeroes every lane after it.
    always_comb begin
        lanes_n = lanes;
        for (int i = 0; i < LANES; i++) begin
            if (PW'(i) == pos)
                lanes_n[LANES-1-i] = byte_data;
            else if (byte_last && PW'(i) > pos)
                lanes_n[LANES-1-i] = '0;
        end
    end

    assign complete = accept && (pos == PW'(LANES-1) || byte_last);
    assign partial  = accept && byte_last && pos != PW'(LANES-1);
    assign word     = lanes;

    always_ff @(posedge clk) begin
        if (!rst) begin
            lanes <= '0;
            pos   <= '0;
        end else if (clear) begin
            pos <= '0;
        end else if (accept) begin
            lanes <= lanes_n;
            pos   <= pos + 1'b1;
        end
    end

endmodule

// File: rtl/instr_mem_loader.sv
// Streams a byte image into instruction memory as big-endian words at
// consecutive word addresses, freezing the CPU (busy) while loading.
module instr_mem_loader
    import instr_mem_loader_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           byte_valid,
    input  logic [INSTRUCTION_MEM_LEN-1:0] byte_data,
    input  logic                           byte_last,
    output logic                           byte_ready,
    output logic [INSTRUCTION_LEN-1:0]     mem_address,
    output logic [INSTRUCTION_LEN-1:0]     mem_write_data,
    output logic                           mem_write,
    output logic                           mem_read,
    output logic                           busy,
    output logic                           done,
    output logic                           error,
    output logic [15:0]                    words_loaded
);

    localparam int IW = $clog2(MAX_WORDS + 1);

    ldr_state_e    state, state_n;
    logic [IW-1:0] index, index_n;
    logic [15:0]   words_n;
    logic          error_n, word_last, word_last_n, wr_n, asm_clear;
    logic          accept, complete, partial, busy_n;

    assign accept = byte_valid && byte_ready;
    assign busy_n = (state_n == LDR_RECV) || (state_n == LDR_WRITE);

    loader_word_assembler u_asm (
        .clk       (clk),
        .rst       (rst),
        .clear     (asm_clear),
        .accept    (accept),
        .byte_data (byte_data),
        .byte_last (byte_last),
        .word      (mem_write_data),
        .complete  (complete),
        .partial   (partial)
    );

    always_comb begin
        state_n     = state;
        index_n     = index;
        words_n     = words_loaded;
        error_n     = error;
        word_last_n = word_last;
        wr_n        = 1'b0;
        asm_clear   = 1'b0;
        case (state)
            LDR_IDLE: if (start) begin
                index_n   = '0;
                words_n   = '0;
                error_n   = 1'b0;
                asm_clear = 1'b1;
                state_n   = LDR_RECV;
            end
            LDR_RECV: if (complete) begin
                word_last_n = byte_last;
                if (partial) error_n = 1'b1;
                // A word with nowhere to go ends the session without a write.
                if (index == IW'(MAX_WORDS)) begin
                    error_n = 1'b1;
                    state_n = LDR_DONE;
                end else begin
                    wr_n    = 1'b1;
                    state_n = LDR_WRITE;
                end
            end
            LDR_WRITE: begin
                index_n   = index + 1'b1;
                words_n   = words_loaded + 16'd1;
                asm_clear = 1'b1;
                state_n   = word_last ? LDR_DONE : LDR_RECV;
            end
            default: state_n = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= LDR_IDLE;
            index        <= '0;
            word_last    <= 1'b0;
            byte_ready   <= 1'b0;
            mem_address  <= INSTRUCTION_LEN'(BASE_ADDR);
            mem_write    <= 1'b0;
            mem_read     <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            state        <= state_n;
            index        <= index_n;
            word_last    <= word_last_n;
            byte_ready   <= (state_n == LDR_RECV);
            mem_address  <= INSTRUCTION_LEN'(BASE_ADDR) + (INSTRUCTION_LEN'(index_n) << 2);
            mem_write    <= wr_n;
            mem_read     <= !busy_n;
            busy         <= busy_n;
            done         <= (state_n == LDR_DONE);
            error        <= error_n;
            words_loaded <= words_n;
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomised scoreboard bench for instr_mem_loader with a byte-stream model.
module tb_instr_mem_loader;
    import instr_mem_loader_pkg::*;

    localparam int MAXW = 2;
    localparam int BASE = 0;

    logic        clk = 0, rst = 0, start = 0, byte_valid = 0, byte_last = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_ready, mem_write, mem_read, busy, done, error;
    logic [31:0] mem_address, mem_write_data;
    logic [15:0] words_loaded;

    always #5 clk = ~clk;

    instr_mem_loader #(.BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk(clk), .rst(rst), .start(start), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read), .busy(busy), .done(done),
        .error(error), .words_loaded(words_loaded)
    );

    typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
    typedef struct { logic err; logic [15:0] words; } st_t;

    int   checks = 0, errors = 0, done_cnt = 0;
    wr_t  exp_wr[$];
    st_t  exp_st[$];
    wr_t  e_wr;
    st_t  e_st;
    logic [7:0] sb[$];
    bit   sl[$];
    bit   prev_wr = 0, last_err = 0;
    int   last_words = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference: walk the byte list, cutting words every 4 bytes or at last.
    task automatic model();
        int nw = 0, p = 0;
        bit err = 0;
        logic [31:0] w = 0;
        for (int i = 0; i < sb.size(); i++) begin
            w[31-8*p -: 8] = sb[i];
            p++;
            if (p == 4 || sl[i]) begin
                if (nw == MAXW) begin err = 1; break; end
                if (p < 4) err = 1;
                exp_wr.push_back('{32'(BASE + 4*nw), w});
                nw++; p = 0; w = 0;
                if (sl[i]) break;
            end
        end
        exp_st.push_back('{err, 16'(nw)});
        last_err = err;
        last_words = nw;
    endtask

    always @(negedge clk) if (rst) begin
        if (mem_write) begin
            chk("strobe_one_cycle", 32'(prev_wr), 0);
            chk("ready_in_write", 32'(byte_ready), 0);
            chk("busy_in_write", 32'(busy), 1);
            if (exp_wr.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr %h data %h want none", mem_address, mem_write_data);
            end else begin
                e_wr = exp_wr.pop_front();
                chk("write_addr", mem_address, e_wr.addr);
                chk("write_data", mem_write_data, e_wr.data);
            end
        end
        if (done) begin
            done_cnt++;
            chk("ready_in_done", 32'(byte_ready), 0);
            chk("busy_in_done", 32'(busy), 0);
            chk("writes_missing", exp_wr.size(), 0);
            exp_wr.delete();
            if (exp_st.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done: got done=1 want none");
            end else begin
                e_st = exp_st.pop_front();
                chk("done_error", 32'(error), 32'(e_st.err));
                chk("done_words", 32'(words_loaded), 32'(e_st.words));
            end
        end
        prev_wr = mem_write;
    end

    task automatic do_start();
        @(negedge clk) start = 1;
        @(negedge clk) start = 0;
        chk("busy_after_start", 32'(busy), 1);
        chk("ready_after_start", 32'(byte_ready), 1);
        chk("mem_read_when_busy", 32'(mem_read), 0);
    endtask

    // Handshake is decided at the negedge: inputs and byte_ready are both stable.
    task automatic send(input bit gaps, input int start_at);
        int i = 0, cyc = 0, d0 = done_cnt;
        bit hs = 0;
        while (1) begin
            @(negedge clk);
            start = 0;
            if (hs) i++;
            if (i >= sb.size() || done_cnt != d0 || cyc > 600) break;
            cyc++;
            byte_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            byte_data  = sb[i];
            byte_last  = sl[i];
            start      = (i == start_at);
            hs         = byte_valid && byte_ready;
        end
        byte_valid = 0; byte_last = 0; start = 0;
        if (cyc > 600) begin
            checks++; errors++;
            $display("FAIL send_timeout: got %0d bytes want %0d", i, sb.size());
        end
    endtask

    task automatic session(input bit gaps, input int start_at);
        int d0 = done_cnt, c = 0;
        model();
        do_start();
        send(gaps, start_at);
        while (done_cnt == d0 && c < 100) begin @(negedge clk); c++; end
        chk("done_seen", 32'(done_cnt - d0), 1);
        repeat (2) @(negedge clk);
        chk("idle_error_sticky", 32'(error), 32'(last_err));
        chk("idle_words_hold", 32'(words_loaded), 32'(last_words));
        chk("idle_mem_read", 32'(mem_read), 1);
    endtask

    task automatic fill_full();
        sb = '{8'hE3, 8'hA0, 8'h00, 8'h14, 8'hE3, 8'hA0, 8'h10, 8'h01};
        sl = '{0, 0, 0, 0, 0, 0, 0, 1};
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", 32'(byte_ready), 0);
        chk("rst_addr", mem_address, BASE);
        chk("rst_wdata", mem_write_data, 0);
        chk("rst_write", 32'(mem_write), 0);
        chk("rst_read", 32'(mem_read), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_error", 32'(error), 0);
        chk("rst_words", 32'(words_loaded), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    initial begin
        int d0, len;
        repeat (3) @(negedge clk);
        chk_reset_state();
        rst = 1;
        repeat (2) @(negedge clk);

        fill_full(); session(0, -1);                  // full load
        fill_full(); session(1, -1);                  // backpressure
        sb = '{8'hAA, 8'hBB}; sl = '{0, 1}; session(0, -1);   // partial word
        sb.delete(); sl.delete();                      // overflow
        for (int i = 0; i < 12; i++) begin sb.push_back(8'($urandom)); sl.push_back(0); end
        session(1, -1);

        // reset after two bytes: no write, no done
        d0 = done_cnt;
        sb = '{8'h11, 8'h22}; sl = '{0, 0};
        do_start();
        send(0, -1);
        @(negedge clk) rst = 0;
        @(negedge clk);
        chk_reset_state();
        rst = 1;
        repeat (6) @(negedge clk);
        chk("no_done_after_abort", 32'(done_cnt), 32'(d0));
        fill_full(); session(0, -1);

        fill_full(); session(1, 5);                   // start while busy

        for (int s = 0; s < 20; s++) begin
            sb.delete(); sl.delete();
            len = $urandom_range(1, 13);
            for (int i = 0; i < len; i++) begin
                sb.push_back(8'($urandom));
                sl.push_back(i == len - 1);
            end
            session(1'($urandom), (len > 2) ? $urandom_range(1, len - 2) : -1);
        end

        repeat (5) @(negedge clk);
        chk("wr_queue_empty", exp_wr.size(), 0);
        chk("st_queue_empty", exp_st.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program loader that writes the ARM core's instruction image into instruction memory. It accepts a byte stream over a valid/ready handshake and packs every 4 bytes into one big-endian 32-bit word, so the first byte received becomes bits 31:24. Each completed word is written to consecutive word-aligned addresses through the memory's write port. It sits between the host or debug link and instruction memory, and holds the CPU in freeze while a load is in progress.

## Interface
- BASE_ADDR, 0: byte address of the first word written; must be a multiple of 4.
- MAX_WORDS, 64: capacity in words, equal to `INSTRUCTION_MEM_SIZE/4.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  single-cycle request that opens a load session; honoured only in IDLE.
- byte_valid  in  1  a byte is offered on byte_data.
- byte_data  in  `INSTRUCTION_MEM_LEN  byte being offered.
- byte_last  in  1  qualifies byte_data as the final byte of the image.
- byte_ready  out  1  the loader can accept a byte this cycle.
- mem_address  out  `INSTRUCTION_LEN  byte address of the word being written.
- mem_write_data  out  `INSTRUCTION_LEN  packed word.
- mem_write  out  1  one-cycle write strobe.
- mem_read  out  1  tied to 0 while busy, 1 otherwise.
- busy  out  1  high from start acceptance until the DONE state is entered; drives the CPU freeze.
- done  out  1  one-cycle pulse when the session ends.
- error  out  1  sticky; set on overflow or on a partial final word; cleared when the next start is accepted.
- words_loaded  out  16  number of words written in the current or last session.

## Operation
- States: IDLE, RECV, WRITE, DONE. Encoding is binary, 2 bits.
- IDLE:
  - byte_ready=0, busy=0.
  - start=1 clears the word index, byte position, words_loaded and error, then moves to RECV.
- RECV:
  - byte_ready=1.
  - On a handshake (byte_valid & byte_ready), the byte is placed at lane pos: lane 0 is [31:24], lane 3 is [7:0]. pos then increments.
  - A byte at pos=3, or any byte with byte_last=1, moves the FSM to WRITE.
  - When byte_last arrives at pos<3, the unfilled lower lanes are written as 0 and error is set.
- WRITE:
  - mem_write=1 for exactly one cycle.
  - mem_address = BASE_ADDR + 4*index; mem_write_data = the packed word.
  - After the write, index and words_loaded increment and pos clears.
  - Next state is DONE if the word carried byte_last, otherwise RECV.
- Overflow: if a word completes while index == MAX_WORDS, the write is suppressed (mem_write stays 0), error is set, and the FSM goes to DONE. Any further bytes are not accepted.
- DONE: done=1 for one cycle, then IDLE.
- start while not in IDLE is ignored.
- byte_valid in IDLE, WRITE or DONE is not accepted because byte_ready is 0; the source holds the byte.
- byte_data and byte_last are sampled only on a handshake.

## Timing
- Reset values (rst=0 at a clock edge): state=IDLE, byte_ready=0, mem_address=BASE_ADDR, mem_write_data=0, mem_write=0, mem_read=1, busy=0, done=0, error=0, words_loaded=0.
- Reset mid-session aborts immediately: no write is issued and no done pulse occurs.
- All outputs are registered.
- mem_address and mem_write_data are stable throughout the mem_write cycle.
- Latency:
  - start at edge N gives busy=1 and byte_ready=1 from N+1.
  - Fourth-byte handshake at edge M gives mem_write=1 during cycle M+1.
  - byte_ready returns to 1 at M+2.
- Peak throughput: 5 cycles per word.
- With byte_last on the final word, done=1 at M+2 and busy=0 from M+2.

## Structure
- Defines.v supplies `INSTRUCTION_LEN and `INSTRUCTION_MEM_LEN.
- A shared loader package or defines file holds the state encodings (LDR_IDLE, LDR_RECV, LDR_WRITE, LDR_DONE) and the MAX_WORDS default.
- One sub-module, loader_word_assembler, holds the lane register, the pos counter, the zero-fill logic and the word-complete flag. The top level contains the FSM, the address and index counters, and the status outputs.

## Test plan
- Full load:
  - Stimulus: start, then bytes E3 A0 00 14, E3 A0 10 01, last on the final byte, byte_valid held high.
  - Required: writes 0xE3A00014 at 0x0 and 0xE3A01001 at 0x4, each strobe 1 cycle; done pulses; error=0; words_loaded=2.
- Backpressure and gaps:
  - Stimulus: byte_valid deasserted randomly.
  - Required: identical writes to the full-load case; no byte is accepted while byte_ready=0 (in WRITE and DONE).
- Partial word:
  - Stimulus: bytes AA BB, with last on BB.
  - Required: writes 0xAABB0000 at 0x0; error=1; done pulses.
- Overflow:
  - Stimulus: MAX_WORDS=2, 12 bytes streamed.
  - Required: exactly 2 writes; the third word is not written; error=1; done pulses; words_loaded=2.
- Reset mid-word:
  - Stimulus: rst=0 after 2 bytes.
  - Required: no mem_write and no done. The next session writes at BASE_ADDR with error=0.
- start while busy:
  - Stimulus: start pulsed during RECV.
  - Required: ignored; index and error unchanged.
